mcif_rd_arbiter: RTL and testbench

Round-robin arbiter that shares one MCIF read channel between `NUM_REQ` read clients, such as the Softmax RDMA and a peer matrix engine. Accepted requests are forwarded through a one-entry output register. Each grant pushes `{client_id, beat_count}` into an order FIFO. MCIF read responses are then steered back, beat by beat and in issue order, to the client that owns the head burst. The block sits between the engine `*2mcif_rd_req_*` / `mcif2*_rd_resp_*` ports and the MCIF read interface.

---
 rtl/mcif_rd_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mcif_rd_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcif_rd_arbiter.sv
// Round-robin arbiter sharing one MCIF read channel between NUM_REQ clients, with in-order
// response steering via an order FIFO. Define MCIF_RD_ARB_PRIO0_EN for strict client-0 priority.
`ifndef log2AXI_BURST_LEN
`define log2AXI_BURST_LEN 4
`endif
`ifndef MAX_DAT_DW
`define MAX_DAT_DW 32
`endif
`ifndef Tout
`define Tout 2
`endif

module mcif_rd_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int ORD_DEPTH      = 16,
   parameter int log2_ORD_DEPTH = 4,
   parameter int PD_W           = `log2AXI_BURST_LEN + 64,
   parameter int DAT_W          = `MAX_DAT_DW * `Tout
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      cli_req_vld,
   output logic [NUM_REQ-1:0]      cli_req_rdy,
   input  logic [NUM_REQ*PD_W-1:0] cli_req_pd,
   output logic                    mcif_rd_req_vld,
   input  logic                    mcif_rd_req_rdy,
   output logic [PD_W-1:0]         mcif_rd_req_pd,
   input  logic                    mcif_rd_resp_vld,
   output logic                    mcif_rd_resp_rdy,
   input  logic [DAT_W-1:0]        mcif_rd_resp_pd,
   output logic [NUM_REQ-1:0]      cli_resp_vld,
   input  logic [NUM_REQ-1:0]      cli_resp_rdy,
   output logic [DAT_W-1:0]        cli_resp_pd,
   input  logic [NUM_REQ-1:0]      cli_rd_fifo_pop,
   output logic                    mcif_rd_fifo_pop,
   output logic                    busy
);

   localparam int LEN_W = PD_W - 64;
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = log2_ORD_DEPTH + 1;

   logic                      req_vld_q, req_vld_d;
   logic [PD_W-1:0]           req_pd_q, req_pd_d;
   logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
   logic [LEN_W-1:0]          beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0]          ord_cnt_q, ord_cnt_d;
   logic [log2_ORD_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [log2_ORD_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ID_W-1:0]           ord_id_q  [ORD_DEPTH];
   logic [ID_W-1:0]           ord_id_d  [ORD_DEPTH];
   logic [LEN_W-1:0]          ord_len_q [ORD_DEPTH];
   logic [LEN_W-1:0]          ord_len_d [ORD_DEPTH];

   logic                      gnt_found;
   logic [ID_W-1:0]           gnt_id;
   logic [PD_W-1:0]           gnt_pd;
   logic                      stage_free;
   logic                      ord_full;
   logic                      ord_empty;
   logic                      grant;
   logic                      rr_adv;
   logic [ID_W-1:0]           h_id;
   logic [LEN_W-1:0]          h_len;
   logic                      beat_acc;
   logic                      pop;

   // Scan all clients starting at rr_ptr; the first valid one wins.
   always_comb begin : arb
      int unsigned     idx;
      logic [ID_W-1:0] sel;
      gnt_found = 1'b0;
      gnt_id    = '0;
      idx       = 0;
      sel       = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = 32'(rr_ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         sel = ID_W'(idx);
         if (!gnt_found && cli_req_vld[sel]) begin
            gnt_found = 1'b1;
            gnt_id    = sel;
         end
      end
`ifdef MCIF_RD_ARB_PRIO0_EN
      if (cli_req_vld[0]) begin
         gnt_found = 1'b1;
         gnt_id    = '0;
      end
`endif
   end

   assign gnt_pd     = cli_req_pd[32'(gnt_id)*PD_W +: PD_W];
   assign stage_free = !req_vld_q | mcif_rd_req_rdy;
   assign ord_full   = (ord_cnt_q == CNT_W'(ORD_DEPTH));
   assign ord_empty  = (ord_cnt_q == '0);
   assign grant      = gnt_found & stage_free & !ord_full;

`ifdef MCIF_RD_ARB_PRIO0_EN
   // Client 0 bypasses the rotation, so its grants leave the pointer alone.
   assign rr_adv = grant & (gnt_id != '0);
`else
   assign rr_adv = grant;
`endif

   assign h_id     = ord_id_q[rd_ptr_q];
   assign h_len    = ord_len_q[rd_ptr_q];
   assign beat_acc = mcif_rd_resp_vld & mcif_rd_resp_rdy;
   assign pop      = beat_acc & (beat_cnt_q == h_len);

   always_comb begin
      cli_req_rdy  = '0;
      cli_resp_vld = '0;
      req_vld_d    = req_vld_q;
      req_pd_d     = req_pd_q;
      rr_ptr_d     = rr_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      ord_cnt_d    = ord_cnt_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      ord_id_d     = ord_id_q;
      ord_len_d    = ord_len_q;

      if (grant) begin
         cli_req_rdy[gnt_id] = 1'b1;
         req_vld_d           = 1'b1;
         req_pd_d            = gnt_pd;
         ord_id_d[wr_ptr_q]  = gnt_id;
         ord_len_d[wr_ptr_q] = gnt_pd[PD_W-1 -: LEN_W];
         wr_ptr_d = (32'(wr_ptr_q) == ORD_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
      end else if (mcif_rd_req_rdy) begin
         req_vld_d = 1'b0;
      end

      if (rr_adv) begin
         rr_ptr_d = (32'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
      end

      if (!ord_empty) begin
         cli_resp_vld[h_id] = mcif_rd_resp_vld;
      end

      if (pop) begin
         beat_cnt_d = '0;
         rd_ptr_d   = (32'(rd_ptr_q) == ORD_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
      end else if (beat_acc) begin
         beat_cnt_d = beat_cnt_q + 1'b1;
      end

      if (grant && !pop) begin
         ord_cnt_d = ord_cnt_q + 1'b1;
      end else if (pop && !grant) begin
         ord_cnt_d = ord_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_vld_q  <= 1'b0;
         req_pd_q   <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         ord_cnt_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         for (int unsigned i = 0; i < ORD_DEPTH; i++) begin
            ord_id_q[i]  <= '0;
            ord_len_q[i] <= '0;
         end
      end else begin
         req_vld_q  <= req_vld_d;
         req_pd_q   <= req_pd_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         ord_cnt_q  <= ord_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ord_id_q   <= ord_id_d;
         ord_len_q  <= ord_len_d;
      end
   end

   assign mcif_rd_req_vld  = req_vld_q;
   assign mcif_rd_req_pd   = req_pd_q;
   assign mcif_rd_resp_rdy = !ord_empty & cli_resp_rdy[h_id];
   assign cli_resp_pd      = mcif_rd_resp_pd;
   assign mcif_rd_fifo_pop = |cli_rd_fifo_pop;
   assign busy             = req_vld_q | !ord_empty;

endmodule

// File: tb/tb_mcif_rd_arbiter.sv
// Bench for mcif_rd_arbiter: vector table, directed corner sequences and a randomized run
// against a queue-based reference model. Honours MCIF_RD_ARB_PRIO0_EN like the design.
module tb_mcif_rd_arbiter;

   localparam int N     = 2;
   localparam int DEPTH = 16;
   localparam int PD_W  = 68;
   localparam int DAT_W = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [N-1:0]      cli_req_vld;
   logic [N-1:0]      cli_req_rdy;
   logic [N*PD_W-1:0] cli_req_pd;
   logic              mcif_rd_req_vld;
   logic              mcif_rd_req_rdy;
   logic [PD_W-1:0]   mcif_rd_req_pd;
   logic              mcif_rd_resp_vld;
   logic              mcif_rd_resp_rdy;
   logic [DAT_W-1:0]  mcif_rd_resp_pd;
   logic [N-1:0]      cli_resp_vld;
   logic [N-1:0]      cli_resp_rdy;
   logic [DAT_W-1:0]  cli_resp_pd;
   logic [N-1:0]      cli_rd_fifo_pop;
   logic              mcif_rd_fifo_pop;
   logic              busy;
   logic [PD_W-1:0]   pd0, pd1;

   assign cli_req_pd = {pd1, pd0};

   always #5 clk = ~clk;

   mcif_rd_arbiter #(
      .NUM_REQ(N), .ORD_DEPTH(DEPTH), .log2_ORD_DEPTH(4), .PD_W(PD_W), .DAT_W(DAT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cli_req_vld(cli_req_vld), .cli_req_rdy(cli_req_rdy), .cli_req_pd(cli_req_pd),
      .mcif_rd_req_vld(mcif_rd_req_vld), .mcif_rd_req_rdy(mcif_rd_req_rdy),
      .mcif_rd_req_pd(mcif_rd_req_pd),
      .mcif_rd_resp_vld(mcif_rd_resp_vld), .mcif_rd_resp_rdy(mcif_rd_resp_rdy),
      .mcif_rd_resp_pd(mcif_rd_resp_pd),
      .cli_resp_vld(cli_resp_vld), .cli_resp_rdy(cli_resp_rdy), .cli_resp_pd(cli_resp_pd),
      .cli_rd_fifo_pop(cli_rd_fifo_pop), .mcif_rd_fifo_pop(mcif_rd_fifo_pop), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n            = 1'b0;
      cli_req_vld      = '0;
      mcif_rd_req_rdy  = 1'b0;
      mcif_rd_resp_vld = 1'b0;
      mcif_rd_resp_pd  = '0;
      cli_resp_rdy     = '0;
      cli_rd_fifo_pop  = '0;
      pd0              = '0;
      pd1              = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mvld"}, mcif_rd_req_vld, 0);
      chk({tag, "_mpd"}, mcif_rd_req_pd, 0);
      chk({tag, "_crdy"}, cli_req_rdy, 0);
      chk({tag, "_cvld"}, cli_resp_vld, 0);
      chk({tag, "_rrdy"}, mcif_rd_resp_rdy, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Spec-level arbitration choice: first valid client at or after rr, modulo N.
   function automatic int pick(input logic [N-1:0] v, input int rr);
`ifdef MCIF_RD_ARB_PRIO0_EN
      if (v[0]) return 0;
`endif
      for (int k = 0; k < N; k++) begin
         if (v[(rr + k) % N]) return (rr + k) % N;
      end
      return -1;
   endfunction

   typedef struct {
      logic [N-1:0] vld;
      logic         mrdy;
      logic [N-1:0] exp_crdy;
      logic         exp_mvld;
      int           exp_src;   // 0: zero payload, 1: client 0, 2: client 1
      logic         exp_busy;
   } vec_t;

   vec_t tbl[9];

   int          q_id[$];
   int          q_len[$];
   int          head_done;
   int          rr;
   logic        m_vld;
   logic [PD_W-1:0] m_pd;
   int          g, hid;
   logic [N-1:0] e_crdy, e_cvld;
   logic        e_rrdy;
   logic [PD_W-1:0] e_pd;
   logic [N-1:0] seq_id;

   initial begin
      // ---------------- table-driven request stage ----------------
      tbl[0] = '{2'b00, 1'b1, 2'b00, 1'b0, 0, 1'b0};
      tbl[1] = '{2'b11, 1'b1, 2'b01, 1'b0, 0, 1'b0};
`ifdef MCIF_RD_ARB_PRIO0_EN
      tbl[2] = '{2'b11, 1'b1, 2'b01, 1'b1, 1, 1'b1};
      tbl[3] = '{2'b11, 1'b0, 2'b00, 1'b1, 1, 1'b1};
      tbl[4] = '{2'b10, 1'b0, 2'b00, 1'b1, 1, 1'b1};
      tbl[5] = '{2'b10, 1'b1, 2'b10, 1'b1, 1, 1'b1};
`else
      tbl[2] = '{2'b11, 1'b1, 2'b10, 1'b1, 1, 1'b1};
      tbl[3] = '{2'b11, 1'b0, 2'b00, 1'b1, 2, 1'b1};
      tbl[4] = '{2'b10, 1'b0, 2'b00, 1'b1, 2, 1'b1};
      tbl[5] = '{2'b10, 1'b1, 2'b10, 1'b1, 2, 1'b1};
`endif
      tbl[6] = '{2'b01, 1'b1, 2'b01, 1'b1, 2, 1'b1};
      tbl[7] = '{2'b00, 1'b1, 2'b00, 1'b1, 1, 1'b1};
      tbl[8] = '{2'b00, 1'b1, 2'b00, 1'b0, 1, 1'b1};

      do_reset();
      chk_reset_outputs("reset");
      pd0 = {4'd0, 64'h0000_0000_1111_0000};
      pd1 = {4'd0, 64'h2222_0000_0000_2222};
      for (int i = 0; i < 9; i++) begin
         cli_req_vld     = tbl[i].vld;
         mcif_rd_req_rdy = tbl[i].mrdy;
         #1;
         e_pd = (tbl[i].exp_src == 1) ? pd0 : (tbl[i].exp_src == 2) ? pd1 : '0;
         chk($sformatf("tbl%0d_crdy", i), cli_req_rdy, tbl[i].exp_crdy);
         chk($sformatf("tbl%0d_mvld", i), mcif_rd_req_vld, tbl[i].exp_mvld);
         chk($sformatf("tbl%0d_mpd", i), mcif_rd_req_pd, e_pd);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
         step();
      end

      // ---------------- single client, len=7 ----------------
      do_reset();
      pd1             = {4'd7, 64'hDEAD_BEEF_0123_4567};
      cli_req_vld     = 2'b10;
      mcif_rd_req_rdy = 1'b1;
      #1;
      chk("single_crdy", cli_req_rdy, 2'b10);
      chk("single_mvld0", mcif_rd_req_vld, 0);
      step();
      cli_req_vld = '0;
      #1;
      chk("single_mvld1", mcif_rd_req_vld, 1);
      chk("single_mpd", mcif_rd_req_pd, pd1);
      step();
      for (int b = 0; b < 8; b++) begin
         mcif_rd_resp_vld = 1'b1;
         mcif_rd_resp_pd  = 64'h1000 + 64'(b);
         cli_resp_rdy     = 2'b11;
         #1;
         chk($sformatf("single_cvld%0d", b), cli_resp_vld, 2'b10);
         chk($sformatf("single_rrdy%0d", b), mcif_rd_resp_rdy, 1);
         chk($sformatf("single_cpd%0d", b), cli_resp_pd, 64'h1000 + 64'(b));
         chk($sformatf("single_busy%0d", b), busy, 1);
         step();
      end
      mcif_rd_resp_vld = 1'b0;
      #1;
      chk("single_busy_end", busy, 0);
      chk("single_rrdy_end", mcif_rd_resp_rdy, 0);

      // ---------------- ordering: 0/len3, 1/len0, 0/len1 ----------------
      do_reset();
      mcif_rd_req_rdy = 1'b1;
      cli_resp_rdy    = 2'b11;
      for (int r = 0; r < 3; r++) begin
         pd0 = {(r == 0) ? 4'd3 : 4'd1, 64'h0A0A_0000_0000_0000 + 64'(r)};
         pd1 = {4'd0, 64'h0B0B_0000_0000_0000};
         cli_req_vld = (r == 1) ? 2'b10 : 2'b01;
         #1;
         chk($sformatf("order_crdy%0d", r), cli_req_rdy, cli_req_vld);
         step();
      end
      cli_req_vld = '0;
      for (int b = 0; b < 7; b++) begin
         mcif_rd_resp_vld = 1'b1;
         seq_id = (b == 4) ? 2'b10 : 2'b01;
         #1;
         chk($sformatf("order_cvld%0d", b), cli_resp_vld, seq_id);
         chk($sformatf("order_rrdy%0d", b), mcif_rd_resp_rdy, 1);
         step();
      end
      mcif_rd_resp_vld = 1'b0;
      #1;
      chk("order_busy_end", busy, 0);

      // ---------------- FIFO full ----------------
      do_reset();
      mcif_rd_req_rdy = 1'b1;
      pd0 = {4'd0, 64'h0000_0000_0000_00F0};
      pd1 = {4'd0, 64'h0000_0000_0000_00F1};
      cli_req_vld = 2'b11;
      for (int i = 0; i < 16; i++) begin
         #1;
`ifdef MCIF_RD_ARB_PRIO0_EN
         chk($sformatf("full_grant%0d", i), cli_req_rdy, 2'b01);
`else
         chk($sformatf("full_grant%0d", i), cli_req_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
`endif
         step();
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("full_block%0d", i), cli_req_rdy, 2'b00);
         step();
      end
      mcif_rd_resp_vld = 1'b1;
      cli_resp_rdy     = 2'b11;
      #1;
      chk("full_popcycle_crdy", cli_req_rdy, 2'b00);
      chk("full_popcycle_rrdy", mcif_rd_resp_rdy, 1);
      step();
      mcif_rd_resp_vld = 1'b0;
      #1;
      chk("full_17th", cli_req_rdy, 2'b01);
      step();
      cli_req_vld = '0;

      // ---------------- response backpressure mid-burst ----------------
      do_reset();
      mcif_rd_req_rdy = 1'b1;
      pd0 = {4'd3, 64'h0000_0000_0000_0C00};
      cli_req_vld = 2'b01;
      #1;
      step();
      cli_req_vld = '0;
      for (int b = 0; b < 6; b++) begin
         mcif_rd_resp_vld = 1'b1;
         cli_resp_rdy     = (b == 2 || b == 3) ? 2'b10 : 2'b11;
         #1;
         chk($sformatf("bp_rrdy%0d", b), mcif_rd_resp_rdy, (b == 2 || b == 3) ? 1'b0 : 1'b1);
         chk($sformatf("bp_cvld%0d", b), cli_resp_vld, 2'b01);
         chk($sformatf("bp_busy%0d", b), busy, 1);
         step();
      end
      mcif_rd_resp_vld = 1'b0;
      #1;
      chk("bp_busy_end", busy, 0);

      // ---------------- reset mid-burst ----------------
      do_reset();
      mcif_rd_req_rdy = 1'b1;
      cli_resp_rdy    = 2'b11;
      pd0 = {4'd7, 64'h0000_0000_0000_0D00};
      cli_req_vld = 2'b01;
      #1;
      step();
      cli_req_vld = '0;
      for (int b = 0; b < 2; b++) begin
         mcif_rd_resp_vld = 1'b1;
         #1;
         step();
      end
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      step();
      rst_n            = 1'b1;
      mcif_rd_resp_vld = 1'b0;
      cli_req_vld      = 2'b11;
      #1;
      chk("midrst_first_grant", cli_req_rdy, 2'b01);
      step();

      // ---------------- randomized run against reference model ----------------
      do_reset();
      q_id.delete();
      q_len.delete();
      head_done = 0;
      rr        = 0;
      m_vld     = 1'b0;
      m_pd      = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         cli_req_vld      = 2'($urandom);
         pd0              = {4'($urandom_range(0, 3)), $urandom, $urandom};
         pd1              = {4'($urandom_range(0, 3)), $urandom, $urandom};
         mcif_rd_req_rdy  = ($urandom_range(0, 3) != 0);
         cli_resp_rdy     = 2'($urandom);
         mcif_rd_resp_vld = (q_id.size() > 0) && ($urandom_range(0, 2) != 0);
         mcif_rd_resp_pd  = {$urandom, $urandom};
         cli_rd_fifo_pop  = 2'($urandom);
         #1;
         g = -1;
         if ((!m_vld || mcif_rd_req_rdy) && q_id.size() < DEPTH) g = pick(cli_req_vld, rr);
         e_crdy = '0;
         if (g >= 0) e_crdy[g] = 1'b1;
         e_cvld = '0;
         e_rrdy = 1'b0;
         hid    = -1;
         if (q_id.size() > 0) begin
            hid = q_id[0];
            e_cvld[hid] = mcif_rd_resp_vld;
            e_rrdy      = cli_resp_rdy[hid];
         end
         chk("rnd_crdy", cli_req_rdy, e_crdy);
         chk("rnd_mvld", mcif_rd_req_vld, m_vld);
         chk("rnd_mpd", mcif_rd_req_pd, m_pd);
         chk("rnd_cvld", cli_resp_vld, e_cvld);
         chk("rnd_rrdy", mcif_rd_resp_rdy, e_rrdy);
         chk("rnd_cpd", cli_resp_pd, mcif_rd_resp_pd);
         chk("rnd_fpop", mcif_rd_fifo_pop, |cli_rd_fifo_pop);
         chk("rnd_busy", busy, m_vld || (q_id.size() > 0));
         if (hid >= 0 && mcif_rd_resp_vld && cli_resp_rdy[hid]) begin
            head_done++;
            if (head_done == q_len[0] + 1) begin
               void'(q_id.pop_front());
               void'(q_len.pop_front());
               head_done = 0;
            end
         end
         if (g >= 0) begin
            e_pd = (g == 0) ? pd0 : pd1;
            q_id.push_back(g);
            q_len.push_back(int'(e_pd[PD_W-1 -: 4]));
            m_vld = 1'b1;
            m_pd  = e_pd;
`ifdef MCIF_RD_ARB_PRIO0_EN
            if (g != 0) rr = (g + 1) % N;
`else
            rr = (g + 1) % N;
`endif
         end else if (mcif_rd_req_rdy) begin
            m_vld = 1'b0;
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
